// File: rtl/srm_cpu.sv
// srm_cpu: two-phase (fetch/execute) RV32I subset core with a halt trap.
// Debug port shows pc at index 0 and architectural registers elsewhere.
module srm_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int REG_COUNT = 32,
  parameter int IM_AW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IM_AW-1:0] imAddr,
  output logic             imReq,
  input  logic [31:0]      imData,
  input  logic             imValid,
  input  logic [4:0]       regAddr,
  output logic [31:0]      regData,
  output logic             retire,
  output logic             halted
);

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    HALT
  } state_t;

  // One bit per register index: set where the register really exists.
  localparam logic [31:0] IMPL =
    (REG_COUNT == 16) ? 32'h0000_fffe : 32'hffff_fffe;

  state_t state, state_nx;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] rf [32];

  logic [6:0]  op;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] imm_i;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] wdata;
  logic [31:0] pc_nx;
  logic        legal;
  logic        wen;
  logic        take;
  logic        jump;

  always_comb begin
    op    = ir[6:0];
    rd    = ir[11:7];
    f3    = ir[14:12];
    rs1   = ir[19:15];
    rs2   = ir[24:20];
    f7    = ir[31:25];
    a     = IMPL[rs1] ? rf[rs1] : 32'd0;
    b     = IMPL[rs2] ? rf[rs2] : 32'd0;
    imm_i = {{20{ir[31]}}, ir[31:20]};
    imm_b = {{19{ir[31]}}, ir[31], ir[7],
             ir[30:25], ir[11:8], 1'b0};
    imm_j = {{11{ir[31]}}, ir[31], ir[19:12],
             ir[20], ir[30:21], 1'b0};
    legal = 1'b1;
    wen   = 1'b1;
    take  = 1'b0;
    jump  = 1'b0;
    wdata = 32'd0;
    unique case (1'b1)
      op == 7'h33 && f7 == 7'h00 && f3 == 3'd0:
        wdata = a + b;
      op == 7'h33 && f7 == 7'h20 && f3 == 3'd0:
        wdata = a - b;
      op == 7'h33 && f7 == 7'h00 && f3 == 3'd6:
        wdata = a | b;
      op == 7'h33 && f7 == 7'h00 && f3 == 3'd5:
        wdata = a >> b[4:0];
      op == 7'h33 && f7 == 7'h00 && f3 == 3'd3:
        wdata = {31'd0, a < b};
      op == 7'h13 && f3 == 3'd0:
        wdata = a + imm_i;
      op == 7'h37:
        wdata = {ir[31:12], 12'd0};
      op == 7'h63 && f3 == 3'd0: begin
        wen  = 1'b0;
        take = (a == b);
      end
      op == 7'h63 && f3 == 3'd1: begin
        wen  = 1'b0;
        take = (a != b);
      end
      op == 7'h6f: begin
        wdata = pc + 32'd4;
        jump  = 1'b1;
      end
      default: begin
        legal = 1'b0;
        wen   = 1'b0;
      end
    endcase
    pc_nx = jump ? pc + imm_j :
            take ? pc + imm_b : pc + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    imReq    = 1'b0;
    retire   = 1'b0;
    halted   = 1'b0;
    unique case (state)
      FETCH: begin
        imReq = 1'b1;
        if (imValid) state_nx = EXEC;
      end
      EXEC: begin
        if (legal) begin
          retire   = 1'b1;
          state_nx = FETCH;
        end else begin
          state_nx = HALT;
        end
      end
      HALT:    halted = 1'b1;
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      ir <= 32'd0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      if (state == FETCH && imValid) ir <= imData;
      if (state == EXEC && legal) begin
        pc <= pc_nx;
        if (wen && IMPL[rd]) rf[rd] <= wdata;
      end
    end
  end

  assign regData = (regAddr == 5'd0) ? pc :
                   IMPL[regAddr] ? rf[regAddr] : 32'd0;

  if (IM_AW > 30) begin : g_wide
    assign imAddr = {{(IM_AW-30){1'b0}}, pc[31:2]};
  end else begin : g_narrow
    assign imAddr = pc[IM_AW+1:2];
  end

endmodule

// File: tb/tb_srm_cpu.sv
// Bench for srm_cpu: two instances (32 and 16 registers) checked each
// cycle against an instruction-level model, plus literal expectations.
module tb_srm_cpu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        im_valid = 1'b0;
  logic [4:0]  reg_addr = 5'd0;
  logic [31:0] mem [64];
  logic [31:0] im_addr [2];
  logic [31:0] im_data [2];
  logic [31:0] reg_data [2];
  logic        im_req [2];
  logic        retire [2];
  logic        halted [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rc0 = 0;
  int rc1 = 0;
  int rlog [$];
  bit chk_en = 1'b0;
  bit sweep_en = 1'b1;
  bit grab = 1'b0;
  logic [31:0] jal_addr = 32'd0;

  always #5 clk = ~clk;

  assign im_data[0] = mem[im_addr[0][5:0]];
  assign im_data[1] = mem[im_addr[1][5:0]];

  srm_cpu #(.RESET_PC(32'h0), .REG_COUNT(32), .IM_AW(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .imAddr(im_addr[0]), .imReq(im_req[0]),
    .imData(im_data[0]), .imValid(im_valid), .regAddr(reg_addr),
    .regData(reg_data[0]), .retire(retire[0]), .halted(halted[0]));

  srm_cpu #(.RESET_PC(32'h0), .REG_COUNT(16), .IM_AW(32)) dut16 (
    .clk(clk), .rst_n(rst_n), .imAddr(im_addr[1]), .imReq(im_req[1]),
    .imData(im_data[1]), .imValid(im_valid), .regAddr(reg_addr),
    .regData(reg_data[1]), .retire(retire[1]), .halted(halted[1]));

  // ---------------- instruction-level model ----------------
  logic [31:0] m_pc [2];
  logic [31:0] m_rf [2][32];
  logic [31:0] m_ir [2];
  bit          m_have [2];
  bit          m_halt [2];

  function automatic int lim(int k);
    return (k == 1) ? 16 : 32;
  endfunction

  function automatic logic [31:0] rdreg(int k, logic [4:0] i);
    if (i == 5'd0 || int'(i) >= lim(k)) return 32'd0;
    return m_rf[k][i];
  endfunction

  function automatic void iss(input int k, input logic [31:0] w,
                              output bit ok, output bit wr,
                              output logic [31:0] val,
                              output logic [31:0] npc);
    logic [31:0] x, y, pc, bi, ji;
    logic [6:0] op, f7;
    logic [2:0] f3;
    x  = rdreg(k, w[19:15]);
    y  = rdreg(k, w[24:20]);
    pc = m_pc[k];
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    bi = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    ji = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    ok = 1'b1;
    wr = 1'b1;
    val = 32'd0;
    npc = pc + 4;
    if (op == 7'h33 && f7 == 0 && f3 == 0) val = x + y;
    else if (op == 7'h33 && f7 == 7'h20 && f3 == 0) val = x - y;
    else if (op == 7'h33 && f7 == 0 && f3 == 6) val = x | y;
    else if (op == 7'h33 && f7 == 0 && f3 == 5) val = x >> y[4:0];
    else if (op == 7'h33 && f7 == 0 && f3 == 3) val = (x < y) ? 1 : 0;
    else if (op == 7'h13 && f3 == 0) val = x + 32'($signed(w[31:20]));
    else if (op == 7'h37) val = {w[31:12], 12'h000};
    else if (op == 7'h63 && f3 <= 1) begin
      wr = 1'b0;
      if ((x == y) == (f3 == 0)) npc = pc + bi;
    end else if (op == 7'h6f) begin
      val = pc + 4;
      npc = pc + ji;
    end else begin
      ok = 1'b0;
      wr = 1'b0;
      npc = pc;
    end
  endfunction

  bit p_ok, p_wr;
  logic [31:0] p_val, p_npc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_pc[k] = 32'h0;
        m_ir[k] = 32'h0;
        m_have[k] = 1'b0;
        m_halt[k] = 1'b0;
        for (int r = 0; r < 32; r++) m_rf[k][r] = 32'h0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!m_halt[k]) begin
          if (m_have[k]) begin
            iss(k, m_ir[k], p_ok, p_wr, p_val, p_npc);
            m_have[k] = 1'b0;
            if (!p_ok) m_halt[k] = 1'b1;
            else begin
              if (p_wr && m_ir[k][11:7] != 0 && int'(m_ir[k][11:7]) < lim(k))
                m_rf[k][m_ir[k][11:7]] = p_val;
              m_pc[k] = p_npc;
            end
          end else if (im_valid) begin
            m_ir[k] = mem[m_pc[k][7:2]];
            m_have[k] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  bit c_ok, c_wr;
  logic [31:0] c_val, c_npc;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        iss(k, m_ir[k], c_ok, c_wr, c_val, c_npc);
        chk("imReq", k, 32'(im_req[k]), 32'(!m_have[k] && !m_halt[k]));
        chk("imAddr", k, im_addr[k], m_pc[k] >> 2);
        chk("retire", k, 32'(retire[k]), 32'(m_have[k] && c_ok));
        chk("halted", k, 32'(halted[k]), 32'(m_halt[k]));
        chk("regData", k, reg_data[k],
            (reg_addr == 0) ? m_pc[k] : rdreg(k, reg_addr));
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc = 0;
    else cyc++;
  end

  always @(negedge clk) begin
    if (grab) begin
      jal_addr = im_addr[0];
      grab = 1'b0;
    end
    if (retire[0]) begin
      rc0++;
      if (rlog.size() < 3) rlog.push_back(cyc + 1);
      if (rc0 == 2) grab = 1'b1;
    end
    if (retire[1]) rc1++;
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sweep_en) reg_addr = reg_addr + 5'd1;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] i_t(int rd, int rs1, int imm);
    return {12'(imm), 5'(rs1), 3'd0, 5'(rd), 7'h13};
  endfunction

  function automatic logic [31:0] r_t(int f7, int f3, int rd, int rs1, int rs2);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] b_t(int f3, int rs1, int rs2, int imm);
    logic [12:1] m;
    m = 12'(imm >>> 1);
    return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:1], m[11], 7'h63};
  endfunction

  function automatic logic [31:0] j_t(int rd, int imm);
    logic [20:1] m;
    m = 20'(imm >>> 1);
    return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6f};
  endfunction

  task automatic load(input logic [31:0] p [$]);
    for (int i = 0; i < 64; i++) mem[i] = 32'hffff_ffff;
    foreach (p[i]) mem[i] = p[i];
  endtask

  task automatic load_at(int idx, logic [31:0] w);
    mem[idx] = w;
  endtask

  task automatic do_reset(bit v);
    @(posedge clk);
    #2 rst_n = 1'b0;
    im_valid = v;
    repeat (2) @(posedge clk);
    rc0 = 0;
    rc1 = 0;
    rlog.delete();
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_halt(string nm);
    int n = 0;
    while (!(halted[0] && halted[1]) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!(halted[0] && halted[1])) begin
      errors++;
      $display("FAIL %s halt timeout got %b%b want 11", nm, halted[0], halted[1]);
    end
    repeat (34) @(posedge clk);
    #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hffff_ffff;
    @(posedge clk);
    #1 chk_en = 1'b1;

    // reset state, observed while rst_n is low
    @(negedge clk);
    chk("rst_imReq", 0, 32'(im_req[0]), 32'd1);
    chk("rst_imAddr", 0, im_addr[0], 32'd0);
    chk("rst_halted", 0, 32'(halted[0]), 32'd0);

    // zero-wait addi/addi/sltu
    load('{32'h0050_0093, 32'hff90_8113, 32'h0020_b1b3});
    do_reset(1'b1);
    wait_halt("t1");
    chk("t1_x1", 0, m_rf[0][1], 32'd5);
    chk("t1_x2", 0, m_rf[0][2], 32'hffff_fffe);
    chk("t1_x3", 0, m_rf[0][3], 32'd1);
    chk("t1_pc", 0, m_pc[0], 32'd12);
    chk("t1_nret", 0, 32'(rlog.size()), 32'd3);
    if (rlog.size() == 3) begin
      chk("t1_ret0", 0, 32'(rlog[0]), 32'd2);
      chk("t1_ret1", 0, 32'(rlog[1]), 32'd4);
      chk("t1_ret2", 0, 32'(rlog[2]), 32'd6);
    end

    // three wait cycles on the first fetch
    do_reset(1'b0);
    repeat (3) @(posedge clk);
    #2 im_valid = 1'b1;
    wait_halt("t2");
    chk("t2_first_ret", 0, (rlog.size() > 0) ? 32'(rlog[0]) : 32'd0, 32'd5);

    // countdown loop with bne
    load('{i_t(1, 0, 3), i_t(1, 1, -1), b_t(1, 1, 0, -4)});
    do_reset(1'b1);
    wait_halt("t3");
    chk("t3_x1", 0, m_rf[0][1], 32'd0);
    chk("t3_pc", 0, m_pc[0], 32'd12);
    chk("t3_nret", 0, 32'(rc0), 32'd7);

    // jal with link, then write to x0
    load('{j_t(0, 32)});
    load_at(8, j_t(5, 16));
    load_at(12, i_t(0, 0, 9));
    load_at(13, i_t(6, 0, 1));
    do_reset(1'b1);
    wait_halt("t4");
    chk("t4_x5", 0, m_rf[0][5], 32'h24);
    chk("t4_imaddr", 0, jal_addr, 32'h0c);
    chk("t4_x6", 0, m_rf[0][6], 32'd1);
    chk("t4_pc", 0, m_pc[0], 32'h38);

    // assorted ALU ops and a taken beq
    load('{{20'h12345, 5'd1, 7'h37}, i_t(1, 1, 12'h678),
           r_t(7'h20, 0, 2, 0, 1), r_t(0, 6, 3, 1, 2),
           i_t(5, 0, 36), r_t(0, 5, 4, 2, 5),
           b_t(0, 4, 4, 8), i_t(6, 0, 1), i_t(7, 0, 2)});
    do_reset(1'b1);
    wait_halt("t5");
    chk("t5_x1", 0, m_rf[0][1], 32'h1234_5678);
    chk("t5_x2", 0, m_rf[0][2], 32'hedcb_a988);
    chk("t5_x3", 0, m_rf[0][3], 32'hffff_fff8);
    chk("t5_x4", 0, m_rf[0][4], 32'h0edc_ba98);
    chk("t5_x6", 0, m_rf[0][6], 32'd0);
    chk("t5_x7", 0, m_rf[0][7], 32'd2);

    // unimplemented registers on the 16-entry core, then illegal at 0x8
    load('{i_t(20, 0, 1), i_t(21, 20, 2)});
    do_reset(1'b1);
    wait_halt("t6");
    chk("t6_x20_32", 0, m_rf[0][20], 32'd1);
    chk("t6_x21_32", 0, m_rf[0][21], 32'd3);
    chk("t6_x20_16", 1, rdreg(1, 5'd20), 32'd0);
    chk("t6_pc16", 1, m_pc[1], 32'd8);
    chk("t6_nret16", 1, 32'(rc1), 32'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_halt", 1, 32'(halted[1]), 32'd0);
    chk("t6_rst_req", 1, 32'(im_req[1]), 32'd1);

    // reset pulse across the execute of addi x1,x0,7
    load('{i_t(1, 0, 7)});
    sweep_en = 1'b0;
    reg_addr = 5'd1;
    do_reset(1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t7_x1", 0, reg_data[0], 32'd0);
    chk("t7_nret", 0, 32'(rc0), 32'd0);
    reg_addr = 5'd0;
    #1;
    chk("t7_pc", 0, reg_data[0], 32'd0);
    sweep_en = 1'b1;
    wait_halt("t7");
    chk("t7_x1_after", 0, m_rf[0][1], 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
